// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge: circular FIFO between the UART receiver and transmitter.
// Bytes flagged by rx_done are queued and handed to the transmitter one at a
// time, each pop waiting for the previous frame to finish (tx_busy handshake).
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   rx_done, rx_data    one-cycle receive strobe and its byte
//   tx_busy             transmitter busy, rises one cycle after tx_start
//   tx_start, tx_data   registered one-cycle start pulse and held byte
//   fifo_empty/full     occupancy flags derived from fifo_count
//   fifo_count          occupancy 0..DEPTH
//   overflow            one-cycle pulse after a byte was dropped
//
// Optional build macro: UART_FIFO_BRIDGE_CRLF_EN
//   When defined, every transmitted 0x0D is followed by an inserted 0x0A
//   (SEND_LF state) that does not consume a FIFO entry.

module uart_fifo_bridge #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx_done,
    input  logic [DATA_WIDTH-1:0]      rx_data,
    input  logic                       tx_busy,
    output logic                       tx_start,
    output logic [DATA_WIDTH-1:0]      tx_data,
    output logic                       fifo_empty,
    output logic                       fifo_full,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

`ifdef UART_FIFO_BRIDGE_CRLF_EN
    localparam logic [DATA_WIDTH-1:0] CR = DATA_WIDTH'(8'h0D);
    localparam logic [DATA_WIDTH-1:0] LF = DATA_WIDTH'(8'h0A);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE,
        SEND_LF
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;
`endif

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         cnt;
    logic [1:0]            wait_cnt;
    logic                  pop;
    logic                  push;
    logic                  drop;

`ifdef UART_FIFO_BRIDGE_CRLF_EN
    logic                  lf_pend;
`endif

    assign fifo_count = cnt;
    assign fifo_empty = (cnt == '0);
    assign fifo_full  = (cnt == CW'(DEPTH));

    // A pop frees a slot in the same cycle, so a full FIFO still
    // accepts a byte when the FSM is popping.
    assign pop  = (state == IDLE) && !fifo_empty && !tx_busy;
    assign push = rx_done && (!fifo_full || pop);
    assign drop = rx_done && fifo_full && !pop;

    // Storage has no reset; contents are qualified by the counter.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= drop;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
            wait_cnt <= '0;
`ifdef UART_FIFO_BRIDGE_CRLF_EN
            lf_pend  <= 1'b0;
`endif
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_data  <= mem[rd_ptr];
                        tx_start <= 1'b1;
                        wait_cnt <= '0;
                        state    <= WAIT_BUSY;
`ifdef UART_FIFO_BRIDGE_CRLF_EN
                        lf_pend  <= (mem[rd_ptr] == CR);
`endif
                    end
                end
                WAIT_BUSY: begin
                    // Fourth idle cycle here means the start was missed.
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (wait_cnt == 2'd3) begin
                        state <= IDLE;
`ifdef UART_FIFO_BRIDGE_CRLF_EN
                        lf_pend <= 1'b0;
`endif
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
`ifdef UART_FIFO_BRIDGE_CRLF_EN
                        state <= lf_pend ? SEND_LF : IDLE;
`else
                        state <= IDLE;
`endif
                    end
                end
`ifdef UART_FIFO_BRIDGE_CRLF_EN
                SEND_LF: begin
                    tx_data  <= LF;
                    tx_start <= 1'b1;
                    lf_pend  <= 1'b0;
                    wait_cnt <= '0;
                    state    <= WAIT_BUSY;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
